// File: rtl/fa_display_ctrl.sv
// fa_display_ctrl: stepped full-adder demo driving a 4-digit common-anode
// seven-segment display. A debounced push button advances {a,b,cin}, the
// slide switch selects the display mode (inputs/total or carry/sum), and the
// four digits are time-multiplexed over one active-low segment bus.
//
// Build option: define FA_DISP_BLANK_EN to blank all anodes for the first
// BLANK_CYCLES cycles of every digit slot (anti-ghosting). Without it the
// selected anode is driven for the whole slot.

module fa_display_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SCAN_CYCLES     = 50000,
  parameter int unsigned BLANK_CYCLES    = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       sw,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [2:0] vec
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned SC_W = $clog2(SCAN_CYCLES);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_CYCLES - 1);

`ifdef FA_DISP_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;

  logic            btn_meta, sync_btn;
  logic            sw_meta, mode;
  logic            btn_state;
  logic [DB_W-1:0] db_cnt;
  logic [SC_W-1:0] scan_cnt;
  logic [1:0]      digit_idx;

  logic       a, b, cin;
  logic       sum, carry;
  logic [1:0] total;
  logic [3:0] code;
  logic       blank;

  // Seven-segment decode, {g..a} active-low; anything outside 0..9 is blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0011000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // Two-flop synchronizers for the asynchronous button and switch.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would collapse the two sync stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      sync_btn <= 1'b0;
      sw_meta  <= 1'b0;
      mode     <= 1'b0;
    end else begin
      btn_meta <= btn;
      sync_btn <= btn_meta;
      sw_meta  <= sw;
      mode     <= sw_meta;
    end
  end

  // Debounce: accept a level after DEBOUNCE_CYCLES differing cycles; a press step advances vec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_state <= 1'b0;
      vec       <= 3'b000;
    end else if (sync_btn == btn_state) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      btn_state <= sync_btn;
      if (sync_btn) begin
        vec <= vec + 3'd1;
      end
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Digit scan: each slot lasts SCAN_CYCLES cycles, digits rotate 0->1->2->3->0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SC_W'(1);
    end
  end

  // Full adder on the current vector.
  assign a     = vec[2];
  assign b     = vec[1];
  assign cin   = vec[0];
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
  assign total = {1'b0, a} + {1'b0, b} + {1'b0, cin};

  assign blank = BLANK_EN && (scan_cnt < SC_W'(BLANK_CYCLES));

  // Select the value shown on the current digit for the active mode.
  always_comb begin
    // NOTE: default assignment first so no path leaves code unassigned (avoids an inferred latch).
    code = CODE_BLANK;
    if (!mode) begin
      case (digit_idx)
        2'd0: code = {2'b00, total};
        2'd1: code = {3'b000, cin};
        2'd2: code = {3'b000, b};
        2'd3: code = {3'b000, a};
        default: code = CODE_BLANK;
      endcase
    end else begin
      case (digit_idx)
        2'd0: code = {3'b000, sum};
        2'd1: code = {3'b000, carry};
        default: code = CODE_BLANK;
      endcase
    end
  end

  // Registered display outputs, refreshed every cycle from the current scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
      dp  <= 1'b1;
    end else begin
      seg <= blank ? SEG_BLANK : seg_decode(code);
      an  <= blank ? 4'b1111 : ~(4'b0001 << digit_idx);
      dp  <= ~((digit_idx == 2'd0) && !mode);
    end
  end

endmodule

// File: tb/tb_fa_display_ctrl.sv
// Testbench for fa_display_ctrl. A reference model derived from sampled input
// history predicts every cycle's outputs; expectations are queued by the
// driver and compared by an independent monitor after each rising edge.

module tb_fa_display_ctrl;

  localparam int DEB   = 4;
  localparam int SCAN  = 8;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       sw  = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [2:0] vec;

  fa_display_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_CYCLES    (SCAN),
    .BLANK_CYCLES   (BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .sw (sw),
    .seg(seg),
    .an (an),
    .dp (dp),
    .vec(vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [2:0] vec;
  } out_t;

  localparam out_t RESET_OUT = '{seg: 7'b1111111, an: 4'b1111, dp: 1'b1, vec: 3'b000};

  out_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model state: edges since reset and the raw input seen at each edge.
  int   k;
  bit   r_hist[$];
  bit   s_hist[$];
  bit   m_state;
  int   m_vec;

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got seg=%b an=%b dp=%b vec=%b, expected seg=%b an=%b dp=%b vec=%b",
               name, $time, act.seg, act.an, act.dp, act.vec, exp.seg, exp.an, exp.dp, exp.vec);
    end
  endtask

  task automatic check_vec(input string name, input int exp);
    checks++;
    if (vec !== 3'(exp)) begin
      fails++;
      $display("FAIL %s @%0t: vec=%b expected %b", name, $time, vec, 3'(exp));
    end
  endtask

  function automatic bit hist(input bit q[$], input int j);
    return (j >= 1 && j < q.size()) ? q[j] : 1'b0;
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic void model_reset();
    k = 0;
    r_hist = {1'b0};
    s_hist = {1'b0};
    m_state = 1'b0;
    m_vec = 0;
  endfunction

  // Called at a falling edge: drive inputs for the next rising edge and queue
  // the outputs the DUT must show right after it.
  task automatic step(input bit b, input bit s);
    out_t e;
    int   idx, sc, va, vb, vc, d;
    bit   mode, acc;
    btn = b;
    sw  = s;
    k++;
    idx  = ((k - 1) / SCAN) % 4;
    sc   = (k - 1) % SCAN;
    mode = hist(s_hist, k - 2);
    va = (m_vec >> 2) & 1;
    vb = (m_vec >> 1) & 1;
    vc = m_vec & 1;
    if (!mode) begin
      d = (idx == 0) ? va + vb + vc : (idx == 1) ? vc : (idx == 2) ? vb : va;
    end else begin
      d = (idx == 0) ? (va + vb + vc) % 2 : (idx == 1) ? ((va + vb + vc) >= 2 ? 1 : 0) : 15;
    end
    e.seg = glyph(d);
    e.an  = ~(4'b0001 << idx);
`ifdef FA_DISP_BLANK_EN
    if (sc < BLANK) begin
      e.seg = 7'b1111111;
      e.an  = 4'b1111;
    end
`endif
    e.dp = !(idx == 0 && !mode);
    // A level is accepted once the synchronized button has differed from the
    // accepted level for DEB consecutive edges.
    acc = 1'b1;
    for (int i = 0; i < DEB; i++) begin
      if (hist(r_hist, k - 2 - i) == m_state) acc = 1'b0;
    end
    if (acc) begin
      m_state = !m_state;
      if (m_state) m_vec = (m_vec + 1) % 8;
    end
    e.vec = 3'(m_vec);
    r_hist.push_back(b);
    s_hist.push_back(s);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input bit b, input bit s, input int n);
    for (int i = 0; i < n; i++) step(b, s);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    btn = 1'b0;
    sw  = 1'b0;
    #1 check("async_reset", {seg, an, dp, vec}, RESET_OUT);
    @(negedge clk);
    check("reset_hold", {seg, an, dp, vec}, RESET_OUT);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: after each rising edge, compare against the oldest expectation.
  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {seg, an, dp, vec}, e);
      end
    end
  end

  initial begin : driver
    int len;
    bit s;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle scan through more than one full refresh period.
    hold(1'b0, 1'b0, 40);

    // Clean press held 20 cycles: exactly one increment.
    hold(1'b1, 1'b0, 20);
    hold(1'b0, 1'b0, 10);
    check_vec("clean_press", 1);

    // Bounce 3 high / 2 low / 10 high: one increment after the final rise.
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 8);
    check_vec("bounce_press", 2);

    // Eight presses from reset wrap vec back to zero.
    do_reset();
    for (int p = 0; p < 8; p++) begin
      hold(1'b1, p[0], 6);
      hold(1'b0, p[0], 6);
    end
    check_vec("wrap_8", 0);

    // vec = 111 shown in both modes for a full refresh each.
    for (int p = 0; p < 7; p++) begin
      hold(1'b1, 1'b0, 6);
      hold(1'b0, 1'b0, 6);
    end
    check_vec("vec_111", 7);
    hold(1'b0, 1'b0, 34);
    hold(1'b0, 1'b1, 36);

    // Reset while debouncing in slot 2 drops the pending press; a short pulse is ignored.
    do_reset();
    hold(1'b0, 1'b0, 17);
    hold(1'b1, 1'b0, 4);
    do_reset();
    hold(1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 12);
    check_vec("short_pulse", 0);

    // Random button pulses and switch changes.
    s = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) s = !s;
      len = $urandom_range(1, 9);
      hold(1'b1, s, len);
      len = $urandom_range(1, 9);
      hold(1'b0, s, len);
    end
    hold(1'b0, s, 10);

    #2;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fa_display_ctrl.md
# fa_display_ctrl

Controller that turns the board's raw push button and slide switch into a stepped full-adder demonstration and time-multiplexes the results onto a shared 4-digit common-anode seven-segment display. It debounces the button, advances a 3-bit input vector {a,b,cin} on each press, evaluates the full adder, and scans four digits over one shared segment bus. It sits between the board I/O pins and the display.

## Interface
- DEBOUNCE_CYCLES, 250000: cycles the synchronized button must differ from its accepted state before the change is accepted (≥2).
- SCAN_CYCLES, 50000: cycles each digit stays selected (≥4).
- BLANK_CYCLES, 500: cycles at the start of each digit slot with all anodes off; used only with FA_DISP_BLANK_EN (1 ≤ BLANK_CYCLES < SCAN_CYCLES).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn  in  1  raw push button, active-high, asynchronous to clk.
- sw  in  1  raw slide switch (display mode), asynchronous to clk.
- seg  out  7  segments {g..a}, active-low, team encoding (0=1000000 … 9=0011000, blank=1111111).
- an  out  4  digit anodes, active-low, an[k] selects digit k.
- dp  out  1  decimal point, active-low.
- vec  out  3  current {a,b,cin} (debug).

## Operation
- Input sync: btn and sw each go through a 2-FF synchronizer (reset to 0).
- Debounce: while sync_btn ≠ btn_state, db_cnt increments. When db_cnt == DEBOUNCE_CYCLES-1, btn_state ← sync_btn and db_cnt ← 0. Any cycle with sync_btn == btn_state clears db_cnt, so a glitch restarts the count.
- Press: a btn_state 0→1 transition increments vec in the same edge. vec wraps 3'b111→3'b000. A release (1→0) has no effect.
- Full adder (combinational): sum = a^b^cin; carry = majority(a,b,cin); total = a+b+cin (0..3).
- Scan: scan_cnt counts 0..SCAN_CYCLES-1. At terminal count it returns to 0 and digit_idx advances 0→1→2→3→0.
- Digit content, mode = sync_sw:
  - Mode 0: d3=a, d2=b, d1=cin, d0=total.
  - Mode 1: d3=blank, d2=blank, d1=carry, d0=sum.
- Codes outside 0..9 display blank.
- dp is 0 (lit) only while digit 0 is selected in mode 0; otherwise 1.
- seg, an and dp are registered and are updated every cycle from the current digit_idx, scan_cnt, vec and mode.

## Timing
- Reset values: seg=7'b1111111, an=4'b1111, dp=1, vec=3'b000, digit_idx=0, scan_cnt=0, db_cnt=0, btn_state=0.
- Reset asserted mid-scan or mid-debounce returns everything to the reset values immediately. A press pending at reset is lost.
- Output latency is one clock. At the first edge after reset deassertion, outputs show digit 0: an=4'b1110 without the macro; blanked with it.
- Button latency: if btn is high and stable from sampling edge 1, vec increments at edge DEBOUNCE_CYCLES+2.
- A pulse shorter than DEBOUNCE_CYCLES cycles (after sync) never changes vec.
- Exactly one increment occurs per accepted press, regardless of hold time.
- Switch latency: a mode change is reflected on seg/dp 3 edges after the raw edge is sampled. The change is immediate within the current digit slot; it does not wait for a slot boundary.
- A vec change is visible on seg at the next edge.
- Refresh period is 4·SCAN_CYCLES cycles. Each slot lasts exactly SCAN_CYCLES cycles.
- Simultaneous scan terminal count and press: both take effect on the same edge, with no interaction.

## Configuration
- FA_DISP_BLANK_EN defined: an=4'b1111 and seg=7'b1111111 for the first BLANK_CYCLES cycles of every digit slot (scan_cnt < BLANK_CYCLES), then the digit is driven for the rest of the slot. This suppresses ghosting.
- FA_DISP_BLANK_EN undefined: the selected anode is driven for the entire slot, BLANK_CYCLES is ignored, and there is no blanking logic.

## Test plan
Parameters for all tests: DEBOUNCE_CYCLES=4, SCAN_CYCLES=8, BLANK_CYCLES=2.
1. Reset, sw=0, no press → after the first edge an=1110, seg=1000000, dp=0. Then an=1101, 1011, 0111 at 8-cycle intervals, all showing "0", dp=1; the sequence wraps back to 1110 at cycle 32.
2. Clean press held for 20 cycles → vec 000→001 exactly 6 edges after btn rises, and no further increment. Digit 1 shows "1" (1111001) and digit 0 shows "1".
3. Bounce: btn high for 3 cycles, low for 2, then high for 10 → exactly one increment, occurring 6 edges after the final rise.
4. Eight presses from reset → vec returns to 000. At vec=3'b111, mode 0 digit 0 shows "3" (0110000). With sw=1, digit 1 shows "1", digit 0 shows "1", and digits 3 and 2 show 1111111.
5. rst asserted while db_cnt=2 and digit_idx=2 → all outputs take reset values asynchronously. After release, a 3-cycle pulse does not change vec.
6. With FA_DISP_BLANK_EN defined → an=1111 for the first 2 cycles of each slot and the selected anode low for the remaining 6. Without the macro, the anode is low for all 8 cycles.
